// File: rtl/phy_tx_encoder_64b66b.sv
// rtl/phy_tx_encoder_64b66b.sv - 64B/66B transmit framer with gearbox sequence and pause-slot handling
// One 66-bit block per non-pause slot: START, DATA, ERROR on underrun, T_n terminate, IDLE.
module phy_tx_encoder_64b66b #(
   parameter int MIN_IPG_BLOCKS = 2,
   parameter int SEQ_MAX        = 32
) (
   input  logic        i_tx_clk,
   input  logic        i_tx_rst,
   input  logic [63:0] s_axis_data,
   input  logic [7:0]  s_axis_keep,
   input  logic        s_axis_last,
   input  logic        s_axis_valid,
   output logic        s_axis_ready,
   output logic [63:0] o_tx_data,
   output logic [1:0]  o_tx_header,
   output logic [6:0]  o_tx_sequence,
   output logic        o_tx_data_valid
);

   localparam logic [3:0]  MIN_IPG   = 4'(MIN_IPG_BLOCKS);
   localparam logic [6:0]  SEQ_LAST  = 7'(SEQ_MAX);
   localparam logic [1:0]  HDR_DATA  = 2'b01;
   localparam logic [1:0]  HDR_CTRL  = 2'b10;
   localparam logic [63:0] IDLE_BLK  = {8'h1E, 56'h0};
   localparam logic [63:0] START_BLK = {8'h78, 48'h555555555555, 8'hD5};
   localparam logic [63:0] ERROR_BLK = {8'h1E, {8{7'h1E}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_TERM,
      ST_GAP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [6:0]  seq_cnt;
   logic [3:0]  gap;
   logic [3:0]  gap_nxt;
   logic [3:0]  keep_cnt;
   logic [63:0] blk;
   logic [1:0]  hdr;
   logic        pause;
   logic        gap_done;

   // Terminate block: type byte selected by byte count, then the first n beat bytes, zero fill.
   function automatic logic [63:0] term_block(input logic [3:0] n, input logic [63:0] d);
      logic [7:0]  t;
      logic [55:0] mask;
      case (n)
         4'd0:    t = 8'h87;
         4'd1:    t = 8'h99;
         4'd2:    t = 8'hAA;
         4'd3:    t = 8'hB4;
         4'd4:    t = 8'hCC;
         4'd5:    t = 8'hD2;
         4'd6:    t = 8'hE1;
         default: t = 8'hFF;
      endcase
      mask = ~({56{1'b1}} >> {n, 3'b000});
      return {t, d[63:8] & mask};
   endfunction

   assign pause    = (seq_cnt == SEQ_LAST);
   assign gap_done = (gap == MIN_IPG);

   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < 8; i++) begin
         keep_cnt = keep_cnt + {3'b000, s_axis_keep[i]};
      end
   end

   always_comb begin
      state_nxt    = state;
      gap_nxt      = gap;
      blk          = IDLE_BLK;
      hdr          = HDR_CTRL;
      s_axis_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (s_axis_valid && gap_done) begin
               blk       = START_BLK;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            s_axis_ready = !pause;
            if (!s_axis_valid) begin
               blk = ERROR_BLK;
            end else if (!s_axis_last) begin
               blk = s_axis_data;
               hdr = HDR_DATA;
            end else if (keep_cnt == 4'd8) begin
               // A full last beat has no room for data in T_n, so T_0 follows separately.
               blk       = s_axis_data;
               hdr       = HDR_DATA;
               state_nxt = ST_TERM;
            end else begin
               blk       = term_block(keep_cnt, s_axis_data);
               gap_nxt   = '0;
               state_nxt = ST_GAP;
            end
         end
         ST_TERM: begin
            blk       = term_block(4'd0, s_axis_data);
            gap_nxt   = '0;
            state_nxt = ST_GAP;
         end
         ST_GAP: begin
            gap_nxt = gap + 4'd1;
            if (gap + 4'd1 == MIN_IPG) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_tx_clk or posedge i_tx_rst) begin
      if (i_tx_rst) begin
         seq_cnt         <= '0;
         o_tx_sequence   <= '0;
         o_tx_data_valid <= 1'b0;
         o_tx_data       <= '0;
         o_tx_header     <= '0;
         state           <= ST_IDLE;
         gap             <= MIN_IPG;
      end else begin
         o_tx_sequence   <= seq_cnt;
         o_tx_data_valid <= !pause;
         seq_cnt         <= pause ? 7'd0 : seq_cnt + 7'd1;
         // The gearbox consumes nothing in the pause slot, so everything else freezes.
         if (!pause) begin
            state       <= state_nxt;
            gap         <= gap_nxt;
            o_tx_data   <= blk;
            o_tx_header <= hdr;
         end
      end
   end

endmodule

// File: tb/tb_phy_tx_encoder_64b66b.sv
// tb/tb_phy_tx_encoder_64b66b.sv - randomized frame bench for the 64B/66B framer
// Expected block stream is built per frame from the block rules; IDLE runs between frames are checked for length.
module tb_phy_tx_encoder_64b66b;

   localparam int MIN_IPG = 2;
   localparam int SEQ_MAX = 32;
   localparam logic [65:0] IDLE_BLK  = {2'b10, 8'h1E, 56'h0};
   localparam logic [65:0] START_BLK = {2'b10, 8'h78, 48'h555555555555, 8'hD5};
   localparam logic [7:0]  TYPE_TAB [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_axis_data;
   logic [7:0]  s_axis_keep;
   logic        s_axis_last;
   logic        s_axis_valid;
   logic        s_axis_ready;
   logic [63:0] o_tx_data;
   logic [1:0]  o_tx_header;
   logic [6:0]  o_tx_sequence;
   logic        o_tx_data_valid;

   always #5 clk = ~clk;

   phy_tx_encoder_64b66b #(
      .MIN_IPG_BLOCKS(MIN_IPG),
      .SEQ_MAX       (SEQ_MAX)
   ) dut (
      .i_tx_clk       (clk),
      .i_tx_rst       (rst),
      .s_axis_data    (s_axis_data),
      .s_axis_keep    (s_axis_keep),
      .s_axis_last    (s_axis_last),
      .s_axis_valid   (s_axis_valid),
      .s_axis_ready   (s_axis_ready),
      .o_tx_data      (o_tx_data),
      .o_tx_header    (o_tx_header),
      .o_tx_sequence  (o_tx_sequence),
      .o_tx_data_valid(o_tx_data_valid)
   );

   int          errors = 0;
   int          checks = 0;
   logic [65:0] q[$];
   logic [65:0] err_blk;
   logic [65:0] prev_blk;
   int          mc;
   int          idle_run;
   bit          ready_window;
   bit          b2b;
   bit          acc;

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [65:0] term_model(input int n, input logic [63:0] d);
      logic [63:0] p;
      p = {TYPE_TAB[n], 56'h0};
      for (int i = 0; i < n; i++) begin
         p[55-8*i -: 8] = d[63-8*i -: 8];
      end
      return {2'b10, p};
   endfunction

   task automatic tick();
      int          exp_seq;
      int          n;
      logic [65:0] obs;
      logic [65:0] e;
      #1;
      acc = s_axis_valid && s_axis_ready;
      chk("ready", 66'(s_axis_ready), 66'(ready_window && mc != SEQ_MAX));
      if (acc) begin
         if (!s_axis_last) begin
            q.push_back({2'b01, s_axis_data});
         end else begin
            ready_window = 1'b0;
            n = $countones(s_axis_keep);
            if (n == 8) begin
               q.push_back({2'b01, s_axis_data});
               q.push_back(term_model(0, 64'h0));
            end else begin
               q.push_back(term_model(n, s_axis_data));
            end
         end
      end
      exp_seq = mc;
      mc = (mc == SEQ_MAX) ? 0 : mc + 1;
      @(posedge clk);
      #1;
      chk("sequence", 66'(o_tx_sequence), 66'(exp_seq));
      chk("data_valid", 66'(o_tx_data_valid), 66'(exp_seq != SEQ_MAX));
      obs = {o_tx_header, o_tx_data};
      if (exp_seq == SEQ_MAX) begin
         chk("pause_hold", obs, prev_blk);
      end else if (q.size() == 0) begin
         chk("idle", obs, IDLE_BLK);
         idle_run++;
      end else if (q[0] == START_BLK && obs != START_BLK) begin
         chk("pre_start_idle", obs, IDLE_BLK);
         idle_run++;
      end else begin
         e = q.pop_front();
         chk("block", obs, e);
         if (e == START_BLK) begin
            chk("ipg_min", 66'(idle_run >= MIN_IPG), 66'(1));
            if (b2b) chk("ipg_exact", 66'(idle_run), 66'(MIN_IPG));
            ready_window = 1'b1;
         end else if (e[65:64] == 2'b10 && e[63:56] != 8'h1E) begin
            idle_run = 0;
         end
      end
      prev_blk = obs;
   endtask

   task automatic send_frame(input int nbeats, input int last_n, input int underrun_at,
                             input bit hold, input bit b2b_flag, input logic [63:0] base);
      b2b = b2b_flag;
      q.push_back(START_BLK);
      for (int i = 0; i < nbeats; i++) begin
         if (i == underrun_at && i > 0) begin
            s_axis_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
               if (mc != SEQ_MAX) q.push_back(err_blk);
               tick();
            end
         end
         s_axis_data  = (base != 64'h0) ? base + 64'(i) : {$urandom, $urandom};
         s_axis_last  = (i == nbeats - 1);
         s_axis_keep  = s_axis_last ? 8'(255 << (8 - last_n)) : 8'($urandom);
         s_axis_valid = 1'b1;
         for (int t = 0; t < 200; t++) begin
            tick();
            if (acc) break;
         end
         chk("handshake", 66'(acc), 66'(1));
      end
      if (!hold) begin
         s_axis_valid = 1'b0;
         s_axis_last  = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  nb;
      int  ln;
      int  ur;
      bit  hold;
      bit  prev_hold;
      rst          = 1'b1;
      s_axis_valid = 1'b0;
      s_axis_data  = '0;
      s_axis_keep  = '0;
      s_axis_last  = 1'b0;
      err_blk      = 66'h1E;
      for (int i = 0; i < 8; i++) err_blk = (err_blk << 7) | 66'h1E;
      err_blk[65:64] = 2'b10;
      mc           = 0;
      idle_run     = 100;
      ready_window = 1'b0;
      b2b          = 1'b0;
      prev_blk     = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 66'(o_tx_data), 66'(0));
      chk("rst_header", 66'(o_tx_header), 66'(0));
      chk("rst_sequence", 66'(o_tx_sequence), 66'(0));
      chk("rst_data_valid", 66'(o_tx_data_valid), 66'(0));
      chk("rst_ready", 66'(s_axis_ready), 66'(0));
      rst = 1'b0;

      repeat (40) tick();

      send_frame(3, 8, -1, 1'b0, 1'b0, 64'hD0D0_0000_0000_0000);
      repeat (6) tick();
      send_frame(1, 3, -1, 1'b0, 1'b0, 64'hAABBCC1122334455);
      repeat (5) tick();
      send_frame(45, 5, 20, 1'b0, 1'b0, 64'h0);
      repeat (4) tick();

      send_frame(4, 8, 2, 1'b1, 1'b0, 64'h0);
      send_frame(3, 2, -1, 1'b1, 1'b1, 64'h0);
      send_frame(2, 0, -1, 1'b0, 1'b1, 64'h0);
      repeat (8) tick();

      prev_hold = 1'b0;
      for (int f = 0; f < 14; f++) begin
         nb   = $urandom_range(1, 10);
         ln   = $urandom_range(0, 8);
         ur   = (nb > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, nb - 1) : -1;
         hold = (f < 13) ? ($urandom_range(0, 1) == 1) : 1'b0;
         send_frame(nb, ln, ur, hold, prev_hold, 64'h0);
         if (!hold) repeat ($urandom_range(0, 5)) tick();
         prev_hold = hold;
      end
      repeat (8) tick();

      // Reset in the middle of a frame: outputs clear at once and no terminate follows.
      b2b = 1'b0;
      q.push_back(START_BLK);
      s_axis_data  = {$urandom, $urandom};
      s_axis_keep  = 8'hFF;
      s_axis_last  = 1'b0;
      s_axis_valid = 1'b1;
      for (int t = 0; t < 100 && !ready_window; t++) tick();
      chk("start_seen", 66'(ready_window), 66'(1));
      repeat (3) tick();
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_data", 66'(o_tx_data), 66'(0));
      chk("midrst_header", 66'(o_tx_header), 66'(0));
      chk("midrst_sequence", 66'(o_tx_sequence), 66'(0));
      chk("midrst_data_valid", 66'(o_tx_data_valid), 66'(0));
      chk("midrst_ready", 66'(s_axis_ready), 66'(0));
      s_axis_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      mc           = 0;
      idle_run     = 100;
      ready_window = 1'b0;
      prev_blk     = '0;
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
